// File: rtl/dct_block_sequencer.sv
// Block sequencer for one 8x8 TwoDDCT core: fill, start, wait, drain.
// Optional watchdog on the core response: define DCT_WATCHDOG_EN.
module dct_block_sequencer #(
  parameter int DATA_W         = 9,
  parameter int COEF_W         = 9,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                [0:0] clock,
  input  logic                      rst_,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_W-1:0]         in_data,
  output logic [64*DATA_W-1:0]      dct_x,
  output logic                      dct_start,
  input  logic [64*COEF_W-1:0]      dct_y,
  input  logic                      dct_xfc,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [COEF_W-1:0]         out_data,
  output logic                      out_last,
  output logic                      busy,
  output logic [15:0]               blocks_done,
  output logic                      err_timeout
);

  typedef enum logic [2:0] {
    IDLE, FILL, START, WAIT, DRAIN
  } state_t;

  state_t            state, state_nxt;
  logic [5:0]        idx;
  logic [COEF_W-1:0] ybuf [64];

`ifdef DCT_WATCHDOG_EN
  localparam logic [15:0] TMO = 16'(TIMEOUT_CYCLES);
  logic [15:0] wdog;
`endif

  assign out_data = ybuf[idx];
  assign out_last = out_valid & (idx == 6'd63);

  always_comb begin
    state_nxt   = state;
    in_ready    = 1'b0;
    dct_start   = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b0;
    err_timeout = 1'b0;
    unique case (state)
      IDLE: state_nxt = FILL;
      FILL: begin
        in_ready = 1'b1;
        if (in_valid && idx == 6'd63)
          state_nxt = START;
      end
      START: begin
        dct_start = 1'b1;
        busy      = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        busy = 1'b1;
        if (dct_xfc)
          state_nxt = DRAIN;
`ifdef DCT_WATCHDOG_EN
        else if (wdog == TMO) begin
          err_timeout = 1'b1;
          state_nxt   = FILL;
        end
`endif
      end
      DRAIN: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready && idx == 6'd63)
          state_nxt = FILL;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge rst_) begin
    if (!rst_)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // idx wraps 63->0 exactly on the FILL->START and DRAIN->FILL handshakes
  always_ff @(posedge clock or negedge rst_) begin
    if (!rst_) begin
      idx         <= 6'd0;
      dct_x       <= '0;
      blocks_done <= 16'd0;
      for (int k = 0; k < 64; k++)
        ybuf[k] <= '0;
    end else begin
      unique case (state)
        FILL: begin
          if (in_valid) begin
            dct_x[idx*DATA_W +: DATA_W] <= in_data;
            idx <= idx + 6'd1;
          end
        end
        WAIT: begin
          if (dct_xfc) begin
            for (int k = 0; k < 64; k++)
              ybuf[k] <= dct_y[k*COEF_W +: COEF_W];
            idx <= 6'd0;
          end
        end
        DRAIN: begin
          if (out_ready) begin
            idx <= idx + 6'd1;
            if (idx == 6'd63)
              blocks_done <= blocks_done + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef DCT_WATCHDOG_EN
  always_ff @(posedge clock or negedge rst_) begin
    if (!rst_)
      wdog <= 16'd0;
    else if (state == START)
      wdog <= 16'd0;
    else if (state == WAIT)
      wdog <= wdog + 16'd1;
  end
`endif

endmodule

// File: tb/tb_dct_block_sequencer.sv
// Directed bench for dct_block_sequencer with a simple core model.
// Watchdog scenario runs when DCT_WATCHDOG_EN is defined.
module tb_dct_block_sequencer;

  localparam int DW = 9;
  localparam int CW = 9;
`ifdef DCT_WATCHDOG_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 256;
`endif

  logic          clock = 1'b0;
  logic          rst_ = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic [64*DW-1:0] dct_x;
  logic          dct_start;
  logic [64*CW-1:0] dct_y = '0;
  logic          xfc_core = 1'b0;
  logic          spur = 1'b0;
  logic          core_en = 1'b1;
  wire           dct_xfc = xfc_core | spur;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [CW-1:0] out_data;
  logic          out_last;
  logic          busy;
  logic [15:0]   blocks_done;
  logic          err_timeout;

  int checks = 0;
  int failures = 0;
  int starts = 0;
  int pend = 0;

  dct_block_sequencer #(
    .DATA_W(DW), .COEF_W(CW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clock(clock), .rst_(rst_),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .dct_x(dct_x), .dct_start(dct_start), .dct_y(dct_y),
    .dct_xfc(dct_xfc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last),
    .busy(busy), .blocks_done(blocks_done),
    .err_timeout(err_timeout)
  );

  always #5 clock = ~clock;

  // core model: xfc one cycle, 10 cycles after the start pulse
  always @(posedge clock) begin
    #2;
    if (!rst_) begin
      pend = 0;
      xfc_core = 1'b0;
    end else begin
      xfc_core = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) xfc_core = 1'b1;
      end
      if (dct_start) begin
        starts++;
        if (core_en) pend = 10;
      end
    end
  end

  task automatic set_y(input bit junk);
    for (int k = 0; k < 64; k++)
      dct_y[k*CW +: CW] = junk ? CW'(9'h0AA) : CW'(-k);
  endtask

  task automatic feed(input int spur_at);
    int n;
    for (int i = 0; i < 64; i++) begin
      in_valid = 1'b1;
      in_data  = DW'(i);
      n = 0;
      while (!in_ready && n < 50) begin
        @(negedge clock);
        n++;
      end
      if (n >= 50) begin
        checks++; failures++;
        $display("FAIL feed_timeout sample=%0d in_ready=%b want 1",
                 i, in_ready);
        break;
      end
      spur = (i == spur_at);
      @(negedge clock);
      spur = 1'b0;
    end
    in_valid = 1'b0;
  endtask

  task automatic check_start();
    int bad;
    checks++;
    if (dct_start !== 1'b1) begin
      failures++;
      $display("FAIL start_pulse got=%b want=1", dct_start);
    end
    bad = 0;
    for (int k = 0; k < 64; k++)
      if (dct_x[k*DW +: DW] !== DW'(k)) bad++;
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL dct_x bad_elems=%0d want=0", bad);
    end
  endtask

  task automatic drain(input bit toggle, input int stop_n);
    int n, w, xat, got;
    logic [CW-1:0] pd;
    logic pl;
    bit stall;
    w = 0; xat = -10;
    while (!out_valid && w < 100) begin
      if (dct_xfc) xat = w;
      @(negedge clock);
      w++;
    end
    checks++;
    if (w !== xat + 1) begin
      failures++;
      $display("FAIL out_latency got=%0d want=%0d", w, xat + 1);
    end
    got = 0; n = 0; stall = 0; pd = '0; pl = 1'b0;
    while (got < stop_n && n < 300) begin
      if (!out_valid) begin
        checks++; failures++;
        $display("FAIL out_valid_drop at=%0d got=0 want=1", got);
        break;
      end
      if (stall) begin
        checks++;
        if (out_data !== pd || out_last !== pl) begin
          failures++;
          $display("FAIL hold data=%0h/%b want=%0h/%b",
                   out_data, out_last, pd, pl);
        end
      end
      out_ready = toggle ? (n % 2 == 0) : 1'b1;
      if (out_ready) begin
        checks++;
        if (out_data !== CW'(-got) || out_last !== (got == 63)) begin
          failures++;
          $display("FAIL coef idx=%0d got=%0h/%b want=%0h/%b", got,
                   out_data, out_last, CW'(-got), (got == 63));
        end
        got++;
      end
      stall = !out_ready;
      pd = out_data;
      pl = out_last;
      @(negedge clock);
      n++;
    end
    out_ready = 1'b0;
    checks++;
    if (got !== stop_n) begin
      failures++;
      $display("FAIL coef_count got=%0d want=%0d", got, stop_n);
    end
    if (!toggle) begin
      checks++;
      if (n !== stop_n) begin
        failures++;
        $display("FAIL bubbles cycles=%0d want=%0d", n, stop_n);
      end
    end
  endtask

  task automatic check_bd(input logic [15:0] want, input string tag);
    checks++;
    if (blocks_done !== want) begin
      failures++;
      $display("FAIL blocks_done_%s got=%0d want=%0d",
               tag, blocks_done, want);
    end
  endtask

  task automatic check_idle_outs(input string tag);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || dct_start !== 1'b0) begin
      failures++;
      $display("FAIL %s v/b/s got=%b%b%b want=000",
               tag, out_valid, busy, dct_start);
    end
    check_bd(16'd0, tag);
  endtask

  task automatic test_reset();
    #1 rst_ = 1'b0;
    repeat (5) @(negedge clock);
    check_idle_outs("reset");
    checks++;
    if (in_ready !== 1'b0 || out_last !== 1'b0 ||
        err_timeout !== 1'b0 || out_data !== '0 || dct_x !== '0) begin
      failures++;
      $display("FAIL reset_misc rdy=%b last=%b err=%b data=%0h want 0",
               in_ready, out_last, err_timeout, out_data);
    end
    rst_ = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL ready_at_release got=%b want=0", in_ready);
    end
    @(negedge clock);
    @(negedge clock);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL ready_after_reset got=%b want=1", in_ready);
    end
  endtask

  task automatic test_basic();
    int s0;
    set_y(1'b0);
    s0 = starts;
    feed(-1);
    check_start();
    drain(1'b0, 64);
    checks++;
    if (starts !== s0 + 1) begin
      failures++;
      $display("FAIL start_count got=%0d want=%0d", starts - s0, 1);
    end
    check_bd(16'd1, "basic");
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL back_to_fill busy/rdy got=%b%b want=01",
               busy, in_ready);
    end
  endtask

  task automatic test_backpressure();
    feed(-1);
    check_start();
    drain(1'b1, 64);
    check_bd(16'd2, "bp");
  endtask

  task automatic test_spurious();
    set_y(1'b1);
    feed(20);
    set_y(1'b0);
    check_start();
    drain(1'b0, 64);
    check_bd(16'd3, "spur");
  endtask

  task automatic test_reset_mid();
    feed(-1);
    repeat (3) @(negedge clock);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL wait_busy got=%b want=1", busy);
    end
    rst_ = 1'b0;
    #1 check_idle_outs("rst_wait");
    @(negedge clock);
    rst_ = 1'b1;
    repeat (2) @(negedge clock);
    feed(-1);
    drain(1'b0, 30);
    rst_ = 1'b0;
    #1 check_idle_outs("rst_drain");
    @(negedge clock);
    rst_ = 1'b1;
    repeat (2) @(negedge clock);
    feed(-1);
    check_start();
    drain(1'b0, 64);
    check_bd(16'd1, "after_rst");
  endtask

`ifdef DCT_WATCHDOG_EN
  task automatic test_watchdog();
    int n;
    logic [15:0] bd;
    bd = blocks_done;
    core_en = 1'b0;
    feed(-1);
    check_start();
    @(negedge clock);
    n = 0;
    while (!err_timeout && n < 100) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (n !== TMO) begin
      failures++;
      $display("FAIL wdog_delay got=%0d want=%0d", n, TMO);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL wdog_no_out got=%b want=0", out_valid);
    end
    check_bd(bd, "wdog");
    @(negedge clock);
    checks++;
    if (in_ready !== 1'b1 || err_timeout !== 1'b0) begin
      failures++;
      $display("FAIL wdog_recover rdy/err got=%b%b want=10",
               in_ready, err_timeout);
    end
    core_en = 1'b1;
  endtask
`endif

  initial begin
    set_y(1'b0);
    test_reset();
    test_basic();
    test_backpressure();
    test_spurious();
    test_reset_mid();
`ifdef DCT_WATCHDOG_EN
    test_watchdog();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
